// File: rtl/proc_pkg.sv
// Shared encodings for the 6-instruction processor: opcodes, controller states,
// datapath select codes and the control-word decoder used by control_unit.
package proc_pkg;

  localparam int unsigned P_WIDTH   = 16;
  localparam int unsigned P_REGBITS = 4;
  localparam int unsigned P_DBITS   = 8;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_ADD   = 4'h2,
    OP_LDC   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMPZ  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_LDC    = 4'd6,
    S_SUB    = 4'd7,
    S_JMPZ   = 4'd8,
    S_JMP    = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    RF_S_ALU   = 2'b00,
    RF_S_MEM   = 2'b01,
    RF_S_CONST = 2'b10
  } rf_sel_t;

  typedef enum logic [1:0] {
    ALU_BYPASS = 2'b00,
    ALU_ADD    = 2'b01,
    ALU_SUB    = 2'b10
  } alu_sel_t;

  typedef struct packed {
    logic                 i_rd;
    logic [P_DBITS-1:0]   d_addr;
    logic                 d_rd;
    logic                 d_wr;
    logic [7:0]           w_data;
    logic [P_REGBITS-1:0] w_addr;
    logic [P_REGBITS-1:0] rp_addr;
    logic [P_REGBITS-1:0] rq_addr;
    logic                 w_wr;
    logic                 rp_rd;
    logic                 rq_rd;
    rf_sel_t              rf_s;
    alu_sel_t             alu_s;
    logic                 halted;
  } ctrl_t;

  // Moore control word for a given state and instruction; everything idles at zero.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: c.i_rd = 1'b1;
      S_LOAD: begin
        c.d_rd   = 1'b1;
        c.d_addr = ir[7:0];
        c.rf_s   = RF_S_MEM;
        c.w_addr = ir[11:8];
        c.w_wr   = 1'b1;
      end
      S_STORE: begin
        c.d_wr    = 1'b1;
        c.d_addr  = ir[7:0];
        c.rp_addr = ir[11:8];
        c.rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.rp_addr = ir[7:4];
        c.rq_addr = ir[3:0];
        c.rp_rd   = 1'b1;
        c.rq_rd   = 1'b1;
        c.alu_s   = (st == S_ADD) ? ALU_ADD : ALU_SUB;
        c.rf_s    = RF_S_ALU;
        c.w_addr  = ir[11:8];
        c.w_wr    = 1'b1;
      end
      S_LDC: begin
        c.rf_s   = RF_S_CONST;
        c.w_data = ir[7:0];
        c.w_addr = ir[11:8];
        c.w_wr   = 1'b1;
      end
      S_JMPZ: begin
        c.rp_addr = ir[11:8];
        c.rp_rd   = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: async clear, increment on fetch, and relative load with a
// sign-extended 8-bit offset applied against the already-incremented PC.
module program_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             jump,
  input  logic [7:0]       offset,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] offset_ext_s;

  assign offset_ext_s = {{(WIDTH-8){offset[7]}}, offset};
  assign pc           = pc_r;

  // PC register; the -1 undoes the fetch increment so targets are relative to the jump itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= '0;
    end else if (jump) begin
      pc_r <= pc_r + offset_ext_s - WIDTH'(1);
    end else if (inc) begin
      pc_r <= pc_r + WIDTH'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Controller for the 6-instruction processor: fetch/decode/execute FSM, IR and
// PC, driving all datapath strobes from registered Moore outputs.
module control_unit
  import proc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int DBITS   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   i_addr,
  output logic               i_rd,
  output logic [DBITS-1:0]   d_addr,
  output logic               d_rd,
  output logic               d_wr,
  output logic [7:0]         rf_w_data,
  output logic [REGBITS-1:0] rf_w_addr,
  output logic [REGBITS-1:0] rf_rp_addr,
  output logic [REGBITS-1:0] rf_rq_addr,
  output logic               rf_w_wr,
  output logic               rf_rp_rd,
  output logic               rf_rq_rd,
  output logic [1:0]         rf_s,
  output logic [1:0]         alu_s,
  input  logic               rf_rp_zero,
  output logic               halted
);

  state_t           state_r, state_nx;
  logic [WIDTH-1:0] ir_r, ir_nx;
  ctrl_t            ctrl_r;
  logic             pc_inc_s, pc_jump_s;

  program_counter #(.WIDTH(WIDTH)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc_s),
    .jump   (pc_jump_s),
    .offset (ir_r[7:0]),
    .pc     (i_addr)
  );

  // Next-state, IR capture and PC control.
  always_comb begin
    state_nx  = state_r;
    ir_nx     = ir_r;
    pc_inc_s  = 1'b0;
    pc_jump_s = 1'b0;
    case (state_r)
      S_INIT:  state_nx = S_FETCH;
      S_FETCH: begin
        ir_nx    = i_data;
        pc_inc_s = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (ir_r[15:12])
          OP_LOAD:  state_nx = S_LOAD;
          OP_STORE: state_nx = S_STORE;
          OP_ADD:   state_nx = S_ADD;
          OP_LDC:   state_nx = S_LDC;
          OP_SUB:   state_nx = S_SUB;
          OP_JMPZ:  state_nx = S_JMPZ;
          default:  state_nx = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_LDC, S_SUB: state_nx = S_FETCH;
      S_JMPZ: begin
        if (rf_rp_zero) begin
          state_nx = S_JMP;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_JMP: begin
        pc_jump_s = 1'b1;
        state_nx  = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_INIT;
    endcase
  end

  // State, IR and control word; the word is decoded from the next state so it lines up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_INIT;
      ir_r    <= '0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_nx;
      ir_r    <= ir_nx;
      ctrl_r  <= decode_ctrl(state_nx, ir_nx);
    end
  end

  assign i_rd       = ctrl_r.i_rd;
  assign d_addr     = ctrl_r.d_addr;
  assign d_rd       = ctrl_r.d_rd;
  assign d_wr       = ctrl_r.d_wr;
  assign rf_w_data  = ctrl_r.w_data;
  assign rf_w_addr  = ctrl_r.w_addr;
  assign rf_rp_addr = ctrl_r.rp_addr;
  assign rf_rq_addr = ctrl_r.rq_addr;
  assign rf_w_wr    = ctrl_r.w_wr;
  assign rf_rp_rd   = ctrl_r.rp_rd;
  assign rf_rq_rd   = ctrl_r.rq_rd;
  assign rf_s       = ctrl_r.rf_s;
  assign alu_s      = ctrl_r.alu_s;
  assign halted     = ctrl_r.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an emulated datapath and memories around the DUT, an
// instruction-level model that queues expected fetches/writes, and a monitor.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_data, i_addr;
  logic        i_rd, d_rd, d_wr;
  logic [7:0]  d_addr, rf_w_data;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic        rf_w_wr, rf_rp_rd, rf_rq_rd, rf_rp_zero, halted;
  logic [1:0]  rf_s, alu_s;

  control_unit dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_addr(i_addr), .i_rd(i_rd),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_w_data(rf_w_data),
    .rf_w_addr(rf_w_addr), .rf_rp_addr(rf_rp_addr), .rf_rq_addr(rf_rq_addr),
    .rf_w_wr(rf_w_wr), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd), .rf_s(rf_s),
    .alu_s(alu_s), .rf_rp_zero(rf_rp_zero), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [15:0] rf [16];
  logic [15:0] dm [256];
  logic [15:0] init_rf [16];
  logic [15:0] init_dm [256];
  logic [15:0] m_rf [16];
  logic [15:0] m_dm [256];
  logic        load_dp = 1'b0;
  logic [15:0] rp_data, rq_data, alu_out, wv;

  assign i_data     = imem[i_addr[7:0]];
  assign rf_rp_zero = (rp_data == 16'h0000);

  always_comb begin
    rp_data = rf_rp_rd ? rf[rf_rp_addr] : 16'h0000;
    rq_data = rf_rq_rd ? rf[rf_rq_addr] : 16'h0000;
    case (alu_s)
      2'b01:   alu_out = rp_data + rq_data;
      2'b10:   alu_out = rp_data - rq_data;
      default: alu_out = rp_data;
    endcase
    case (rf_s)
      2'b01:   wv = d_rd ? dm[d_addr] : 16'h0000;
      2'b10:   wv = {8'h00, rf_w_data};
      default: wv = alu_out;
    endcase
  end

  // Emulated operational block: commits writes on the edge leaving the execute state.
  always @(posedge clk) begin
    if (load_dp) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_rf[i];
      for (int i = 0; i < 256; i++) dm[i] <= init_dm[i];
    end else begin
      if (rf_w_wr) rf[rf_w_addr] <= wv;
      if (d_wr) dm[d_addr] <= rp_data;
    end
  end

  // kind: 0 fetch, 1 register write, 2 memory write, 3 halt entry
  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] v;
    logic [3:0]  sel;
    int          gap;
  } ev_t;

  ev_t         exp_q [$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, last_fetch = 0;
  bit          checking = 1'b0;
  bit          halted_q = 1'b0;
  bit          halted_exp = 1'b0;
  logic [15:0] halt_pc = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-set model: walks the program and queues what the controller must produce.
  task automatic model_run(input int k);
    logic [15:0] pc, ins, nx, v;
    logic [3:0]  ra, rb, rc;
    logic [7:0]  lo;
    int          gap;
    bit          stop;
    pc = 16'h0000; gap = -1; stop = 1'b0;
    for (int n = 0; n < k && !stop; n++) begin
      ins = imem[pc[7:0]];
      exp_q.push_back('{0, pc, 16'h0000, 4'h0, gap});
      ra = ins[11:8]; rb = ins[7:4]; rc = ins[3:0]; lo = ins[7:0];
      nx = pc + 16'd1; gap = 3;
      case (ins[15:12])
        4'h0: begin v = m_dm[lo]; m_rf[ra] = v; exp_q.push_back('{1, {12'h000, ra}, v, 4'b0100, 0}); end
        4'h1: begin m_dm[lo] = m_rf[ra]; exp_q.push_back('{2, {8'h00, lo}, m_rf[ra], 4'h0, 0}); end
        4'h2: begin v = m_rf[rb] + m_rf[rc]; m_rf[ra] = v; exp_q.push_back('{1, {12'h000, ra}, v, 4'b0001, 0}); end
        4'h3: begin v = {8'h00, lo}; m_rf[ra] = v; exp_q.push_back('{1, {12'h000, ra}, v, 4'b1000, 0}); end
        4'h4: begin v = m_rf[rb] - m_rf[rc]; m_rf[ra] = v; exp_q.push_back('{1, {12'h000, ra}, v, 4'b0010, 0}); end
        4'h5: begin
          if (m_rf[ra] == 16'h0000) begin
            nx  = pc + {{8{lo[7]}}, lo};
            gap = 4;
          end
        end
        default: begin
          exp_q.push_back('{3, pc + 16'd1, 16'h0000, 4'h0, 0});
          halted_exp = 1'b1;
          halt_pc    = pc + 16'd1;
          stop       = 1'b1;
        end
      endcase
      pc = nx;
    end
  endtask

  // Monitor: every fetch, write or halt entry pops one expectation.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    cyc++;
    if (checking && !reset) begin
      if (i_rd || rf_w_wr || d_wr || (halted && !halted_q)) begin
        kind = i_rd ? 0 : (rf_w_wr ? 1 : (d_wr ? 2 : 3));
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          if (kind == e.kind) begin
            case (kind)
              0: begin
                chk("fetch_addr", 32'(i_addr), 32'(e.a));
                if (e.gap >= 0) chk("fetch_cycles", 32'(cyc - last_fetch), 32'(e.gap));
              end
              1: begin
                chk("rf_w_addr", 32'(rf_w_addr), 32'(e.a));
                chk("rf_w_value", 32'(wv), 32'(e.v));
                chk("rf_alu_sel", 32'({rf_s, alu_s}), 32'(e.sel));
              end
              2: begin
                chk("d_addr", 32'(d_addr), 32'(e.a));
                chk("d_wr_value", 32'(rp_data), 32'(e.v));
              end
              default: chk("halt_pc", 32'(i_addr), 32'(e.a));
            endcase
          end
        end
        if (kind == 0) last_fetch = cyc;
        if (exp_q.size() == 0) checking = 1'b0;
      end else begin
        chk("idle_strobes", 32'({d_rd, rf_rq_rd, rf_s, alu_s}), 32'd0);
      end
    end
    halted_q = halted;
  end

  task automatic run_prog(input int k);
    int t;
    reset = 1'b1;
    load_dp = 1'b1;
    for (int i = 0; i < 16; i++) m_rf[i] = init_rf[i];
    for (int i = 0; i < 256; i++) m_dm[i] = init_dm[i];
    exp_q.delete();
    halted_exp = 1'b0;
    model_run(k);
    @(posedge clk);
    #1 load_dp = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    while (checking && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (checking) begin
      chk("timeout_pending", 32'(exp_q.size()), 32'd0);
      checking = 1'b0;
      exp_q.delete();
    end
    if (halted_exp) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1 chk("halt_quiet", 32'({i_rd, d_rd, d_wr, rf_w_wr, rf_rp_rd, rf_rq_rd, halted, i_addr}),
               32'({7'b0000001, halt_pc}));
      end
    end
  endtask

  function automatic logic [15:0] rand_ins();
    logic [3:0] op;
    logic [7:0] lo;
    int         s;
    op = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
    lo = 8'($urandom_range(0, 255));
    if (op == 4'h5) begin
      s  = $urandom_range(0, 9);
      lo = (s == 0) ? 8'h80 : ((s == 1) ? 8'h00 : 8'($urandom_range(0, 12)) - 8'd6);
    end
    return {op, 4'($urandom_range(0, 15)), lo};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin imem[i] = 16'h0000; init_dm[i] = 16'h0000; end
    for (int i = 0; i < 16; i++) init_rf[i] = 16'h0000;
  endtask

  initial begin
    int t;
    clear_all();
    #12;
    chk("reset_addr", {i_addr, d_addr, rf_w_data}, 32'd0);
    chk("reset_ctrl", 32'({i_rd, d_rd, d_wr, rf_w_addr, rf_rp_addr, rf_rq_addr,
                           rf_w_wr, rf_rp_rd, rf_rq_rd, rf_s, alu_s, halted}), 32'd0);

    // LDC/LDC/ADD/STORE/LOAD/SUB then a taken JMPZ looping back to 4
    imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h2012; imem[3] = 16'h1010;
    imem[4] = 16'h0410; imem[5] = 16'h4321; imem[6] = 16'h55FE;
    run_prog(12);

    clear_all();
    imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h2012; imem[3] = 16'h7000;
    run_prog(10);
    reset = 1'b1;
    #1 chk("reset_clears_halt", 32'({halted, i_addr}), 32'd0);

    // backward jump from 0 lands at 0xFFFE, then the PC wraps to 0 on fetch
    clear_all();
    imem[0] = 16'h55FE; imem[8'hFE] = 16'h3105; imem[8'hFF] = 16'h3203;
    run_prog(9);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) begin
        imem[i]    = rand_ins();
        init_dm[i] = 16'($urandom());
      end
      for (int i = 0; i < 16; i++) init_rf[i] = 16'($urandom_range(0, 2));
      run_prog(30);
    end

    // reset asserted in the middle of an ADD execute cycle
    clear_all();
    imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h2012;
    init_rf[0] = 16'h1234;
    reset = 1'b1; load_dp = 1'b1;
    @(posedge clk);
    #1 load_dp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("first_fetch", 32'({i_rd, i_addr}), 32'h0001_0000);
    t = 0;
    while (!(rf_w_wr && alu_s == 2'b01) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("add_reached", 32'({rf_w_wr, alu_s}), 32'b101);
    #2 reset = 1'b1;
    #1 chk("reset_drops_wr", 32'(rf_w_wr), 32'd0);
    @(posedge clk);
    #1 chk("dest_unchanged", 32'(rf[0]), 32'h1234);
    chk("r1_written", 32'(rf[1]), 32'd5);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("refetch_zero", 32'({i_rd, i_addr}), 32'h0001_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
